// File: rtl/ex_muldiv_seq_pkg.sv
// Shared types and helpers for the RV32M multiply/divide sequencer.
package ex_muldiv_seq_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    MDS_IDLE = 2'b00,
    MDS_RUN  = 2'b01,
    MDS_DONE = 2'b10
  } mds_state_e;

  function automatic logic op_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
  endfunction

  function automatic logic op_rs1_signed(input md_op_e op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic op_rs2_signed(input md_op_e op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic op_is_rem(input md_op_e op);
    return (op == MD_REM) || (op == MD_REMU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on unsigned magnitudes: shift-add multiply or
// restoring shift-subtract divide.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            i_div,
  input  logic [XLEN-1:0] i_acc,
  input  logic [XLEN-1:0] i_quot,
  input  logic [XLEN-1:0] i_opnd,
  output logic [XLEN-1:0] o_acc,
  output logic [XLEN-1:0] o_quot
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_sh;
  logic [XLEN:0] w_diff;
  logic          w_ge;

  // Partial remainder stays below the divisor, so the shifted value is under
  // twice the divisor and bit XLEN of the difference is a clean borrow flag.
  always_comb begin
    w_sum  = {1'b0, i_acc} + (i_quot[0] ? {1'b0, i_opnd} : '0);
    w_sh   = {i_acc, i_quot[XLEN-1]};
    w_diff = w_sh - {1'b0, i_opnd};
    w_ge   = ~w_diff[XLEN];
    if (i_div) begin
      o_acc  = w_ge ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0];
      o_quot = {i_quot[XLEN-2:0], w_ge};
    end else begin
      o_acc  = w_sum[XLEN:1];
      o_quot = {w_sum[0], i_quot[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// EX-stage sequencer for RV32M MUL/DIV/REM; stalls the front end while iterating.
//   IDLE | waiting for an op from E
//   RUN  | one radix-2 step per cycle, cnt counting down
//   DONE | result valid for one cycle, front end released
module ex_muldiv_seq
  import ex_muldiv_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            E_start_i,
  input  logic [2:0]      E_funct3_i,
  input  logic [XLEN-1:0] E_src1_i,
  input  logic [XLEN-1:0] E_src2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int              CNT_W   = $clog2(XLEN);
  localparam logic [XLEN-1:0] ONE     = XLEN'(1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mds_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  md_op_e          r_op;
  logic            r_neg;
  logic [XLEN-1:0] r_acc, r_quot, r_opnd;

  md_op_e          w_op_in;
  logic            w_s1_neg, w_s2_neg, w_neg_in;
  logic            w_div0, w_ovf, w_start_ok, w_run;
  logic [XLEN-1:0] w_mag1, w_mag2, w_step_acc, w_step_quot, w_res;

  assign w_op_in  = md_op_e'(E_funct3_i);
  assign w_s1_neg = op_rs1_signed(w_op_in) & E_src1_i[XLEN-1];
  assign w_s2_neg = op_rs2_signed(w_op_in) & E_src2_i[XLEN-1];
  assign w_mag1   = w_s1_neg ? (~E_src1_i + ONE) : E_src1_i;
  assign w_mag2   = w_s2_neg ? (~E_src2_i + ONE) : E_src2_i;
  assign w_div0   = op_is_div(w_op_in) & (E_src2_i == '0);
  assign w_ovf    = op_is_div(w_op_in) & op_rs1_signed(w_op_in)
                  & (E_src1_i == MIN_NEG) & (&E_src2_i);
  assign w_neg_in = (w_op_in == MD_MUL)  ? 1'b0 :
                    op_is_rem(w_op_in)   ? w_s1_neg : (w_s1_neg ^ w_s2_neg);

  muldiv_step #(.XLEN(XLEN)) u_step (
    .i_div  (op_is_div(r_op)),
    .i_acc  (r_acc),
    .i_quot (r_quot),
    .i_opnd (r_opnd),
    .o_acc  (w_step_acc),
    .o_quot (w_step_quot)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_run       = 1'b0;
    stall_o     = 1'b0;
    done_o      = 1'b0;
    case (r_state)
      MDS_IDLE: if (E_start_i) begin
        stall_o     = 1'b1;
        w_start_ok  = 1'b1;
        w_state_nxt = (w_div0 | w_ovf) ? MDS_DONE : MDS_RUN;
      end
      MDS_RUN: begin
        stall_o = 1'b1;
        w_run   = 1'b1;
        if (r_cnt == '0) w_state_nxt = MDS_DONE;
      end
      MDS_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = MDS_IDLE;
      end
      default: w_state_nxt = MDS_IDLE;
    endcase
    if (flush_i) begin
      stall_o     = 1'b0;
      done_o      = 1'b0;
      w_start_ok  = 1'b0;
      w_run       = 1'b0;
      w_state_nxt = MDS_IDLE;
    end
  end

  // Special cases preload the final values with r_neg=0 so DONE needs no extra path.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= MDS_IDLE;
      r_cnt   <= '0;
      r_op    <= MD_MUL;
      r_neg   <= 1'b0;
      r_acc   <= '0;
      r_quot  <= '0;
      r_opnd  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) begin
        r_op  <= w_op_in;
        r_cnt <= CNT_W'(XLEN-1);
        if (w_div0) begin
          r_neg <= 1'b0; r_quot <= '1;      r_acc <= E_src1_i; r_opnd <= '0;
        end else if (w_ovf) begin
          r_neg <= 1'b0; r_quot <= MIN_NEG; r_acc <= '0;       r_opnd <= '0;
        end else if (op_is_div(w_op_in)) begin
          r_neg <= w_neg_in; r_quot <= w_mag1; r_acc <= '0; r_opnd <= w_mag2;
        end else begin
          r_neg <= w_neg_in; r_quot <= w_mag2; r_acc <= '0; r_opnd <= w_mag1;
        end
      end else if (w_run) begin
        r_cnt  <= r_cnt - CNT_W'(1);
        r_acc  <= w_step_acc;
        r_quot <= w_step_quot;
      end
    end
  end

  // High word of a negated 2*XLEN product: invert, carry in only if low word is zero.
  always_comb begin
    w_res = '0;
    case (r_op)
      MD_MUL:                       w_res = r_quot;
      MD_MULH, MD_MULHSU, MD_MULHU: w_res = r_neg ? (~r_acc + ((r_quot == '0) ? ONE : '0)) : r_acc;
      MD_DIV, MD_DIVU:              w_res = r_neg ? (~r_quot + ONE) : r_quot;
      default:                      w_res = r_neg ? (~r_acc + ONE) : r_acc;
    endcase
  end

  assign busy_o   = (r_state != MDS_IDLE);
  assign result_o = done_o ? w_res : '0;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed and random checks of ex_muldiv_seq against a 64-bit arithmetic reference.
module tb_ex_muldiv_seq;

  logic        clk_i      = 1'b0;
  logic        rst_n_i    = 1'b0;
  logic        E_start_i  = 1'b0;
  logic [2:0]  E_funct3_i = 3'd0;
  logic [31:0] E_src1_i   = 32'd0;
  logic [31:0] E_src2_i   = 32'd0;
  logic        flush_i    = 1'b0;
  logic        stall_o, busy_o, done_o;
  logic [31:0] result_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  ex_muldiv_seq #(.XLEN(32)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .E_start_i  (E_start_i),
    .E_funct3_i (E_funct3_i),
    .E_src1_i   (E_src1_i),
    .E_src2_i   (E_src2_i),
    .flush_i    (flush_i),
    .stall_o    (stall_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0]        p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    p  = 64'd0;
    case (f)
      3'd0: begin p = sa * sb;                              return p[31:0];  end
      3'd1: begin p = sa * sb;                              return p[63:32]; end
      3'd2: begin p = sa * $signed({32'd0, b});             return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b};              return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin if (b == 32'd0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin if (b == 32'd0) return a; return a % b; end
    endcase
  endfunction

  function automatic int ref_stalls(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f >= 3'd4 && b == 32'd0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Entered one time unit after a rising edge with the DUT idle; returns the
  // same distance after the edge that ends the DONE cycle, start still high.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    logic [31:0] exp_res, got;
    int          stalls, dones, nz, exp_st;
    exp_res    = ref_model(f, a, b);
    exp_st     = ref_stalls(f, a, b);
    E_start_i  = 1'b1;
    E_funct3_i = f;
    E_src1_i   = a;
    E_src2_i   = b;
    stalls = 0; dones = 0; nz = 0; got = 32'd0;
    for (int c = 0; c < 80 && dones == 0; c++) begin
      #1;
      if (stall_o) stalls++;
      if (done_o) begin dones++; got = result_o; end
      else if (result_o !== 32'd0) nz++;
      @(posedge clk_i); #1;
    end
    check({tag, "_done"},  32'(dones),  32'd1);
    check({tag, "_res"},   got,         exp_res);
    check({tag, "_stall"}, 32'(stalls), 32'(exp_st));
    check({tag, "_res0"},  32'(nz),     32'd0);
  endtask

  task automatic drop_start(input string tag);
    E_start_i = 1'b0;
    #1;
    check({tag, "_nodone"}, {31'd0, done_o}, 32'd0);
    check({tag, "_idle"},   {31'd0, busy_o}, 32'd0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_stall",  {31'd0, stall_o}, 32'd0);
    check("rst_busy",   {31'd0, busy_o},  32'd0);
    check("rst_done",   {31'd0, done_o},  32'd0);
    check("rst_result", result_o,         32'd0);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    do_op(3'd0, 32'd7,          32'hFFFF_FFFD, "mul_7_m3");     drop_start("mul_7_m3");
    do_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, "mulhu_max");    drop_start("mulhu_max");
    do_op(3'd1, 32'h8000_0000,  32'h8000_0000, "mulh_min");     drop_start("mulh_min");
    do_op(3'd4, 32'hFFFF_FFF9,  32'd2,         "div_m7_2");     drop_start("div_m7_2");
    do_op(3'd6, 32'hFFFF_FFF9,  32'd2,         "rem_m7_2");     drop_start("rem_m7_2");
    do_op(3'd5, 32'd100,        32'd7,         "divu_100_7");   drop_start("divu_100_7");
    do_op(3'd7, 32'd100,        32'd7,         "remu_100_7");   drop_start("remu_100_7");
    do_op(3'd4, 32'd5,          32'd0,         "div_5_0");      drop_start("div_5_0");
    do_op(3'd6, 32'd5,          32'd0,         "rem_5_0");      drop_start("rem_5_0");
    do_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, "div_ovf");      drop_start("div_ovf");
    do_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, "rem_ovf");      drop_start("rem_ovf");

    // Flush while RUN with cnt=10: 22 edges after the accepting IDLE cycle.
    E_start_i = 1'b1; E_funct3_i = 3'd4; E_src1_i = 32'd1000; E_src2_i = 32'd3;
    repeat (22) @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    #1;
    check("flush_stall", {31'd0, stall_o}, 32'd0);
    check("flush_done",  {31'd0, done_o},  32'd0);
    check("flush_busy",  {31'd0, busy_o},  32'd1);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    check("flush_idle",  {31'd0, busy_o},  32'd0);
    do_op(3'd2, 32'hFFFF_FFFB, 32'd3, "post_flush");            drop_start("post_flush");

    // Asynchronous reset in the middle of RUN.
    E_start_i = 1'b1; E_funct3_i = 3'd0; E_src1_i = 32'd123; E_src2_i = 32'd456;
    repeat (10) @(posedge clk_i);
    #1;
    rst_n_i = 1'b0; E_start_i = 1'b0;
    #1;
    check("arst_stall",  {31'd0, stall_o}, 32'd0);
    check("arst_busy",   {31'd0, busy_o},  32'd0);
    check("arst_done",   {31'd0, done_o},  32'd0);
    check("arst_result", result_o,         32'd0);
    #2 rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("arst_quiet%0d", i), {31'd0, done_o | busy_o}, 32'd0);
      @(posedge clk_i); #1;
    end

    do_op(3'd5, 32'd1000,       32'd33,        "b2b_a");
    do_op(3'd0, 32'h1234_5678,  32'h9ABC_DEF0, "b2b_b");        drop_start("b2b_b");

    for (int i = 0; i < 24; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      do_op(f, a, b, $sformatf("rnd%0d_f%0d", i, f));
      drop_start($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
